// File: rtl/gf2_trinomial_reducer_if.sv
// Handshake/data bundle between a GF(2^M) multiplier and the trinomial reducer.
// The err signal exists only when GF2_RED_ERR_EN is defined.
interface gf2_trinomial_reducer_if #(
    parameter int M = 1120
);
    logic           start;
    logic [2*M-1:0] W;
    logic [M-1:0]   R;
    logic           busy;
    logic           done;
`ifdef GF2_RED_ERR_EN
    logic           err;

    modport master (output start, W, input R, busy, done, err);
    modport slave  (input start, W, output R, busy, done, err);
`else
    modport master (output start, W, input R, busy, done);
    modport slave  (input start, W, output R, busy, done);
`endif
endinterface

// File: rtl/gf2_trinomial_reducer.sv
// Reduces a 2M-bit GF(2) product modulo x^M + x^K + 1 in two fold steps (three-edge latency).
// Optional macro GF2_RED_ERR_EN adds err, which captures W[0] on every accepted start.
module gf2_trinomial_reducer #(
    parameter int M = 1120,
    parameter int K = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    gf2_trinomial_reducer_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, FOLD1, FOLD2} state_t;

    state_t         state;
    logic [2*M-2:0] acc;
    logic [M-1:0]   r_q;
    logic           busy_q;
    logic           done_q;

    // x^M == x^K + 1, so the high half H folds back as H ^ (H << K).
    // With K <= M/2 the second fold leaves nothing above bit M-1.
    logic [M-2:0]   h;
    logic [M-1:0]   l;
    logic [2*M-2:0] fold;

    always_comb begin
        h    = acc[2*M-2:M];
        l    = acc[M-1:0];
        fold = {{(M-1){1'b0}}, l} ^ {{M{1'b0}}, h} ^ ({{M{1'b0}}, h} << K);
    end

`ifdef GF2_RED_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_q <= 1'b0;
        else if (state == IDLE && bus.start)
            err_q <= bus.W[0];
    end

    assign bus.err = err_q;
`else
    logic unused_w0;
    assign unused_w0 = bus.W[0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            r_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= bus.W[2*M-1:1];
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= FOLD1;
                    end
                end
                FOLD1: begin
                    acc   <= fold;
                    state <= FOLD2;
                end
                FOLD2: begin
                    acc    <= fold;
                    r_q    <= fold[M-1:0];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.R    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_gf2_trinomial_reducer.sv
// Self-checking bench for gf2_trinomial_reducer: vector table, corner sequences and
// randomized products checked against a bit-serial long-division model.
module tb_gf2_trinomial_reducer;
    localparam int M = 1120;
    localparam int K = 9;

    logic clk = 1'b0;
    logic reset;
    int   nchecks = 0;
    int   nerr = 0;
    int   done_rises = 0;

    always #5 clk = ~clk;

    gf2_trinomial_reducer_if #(.M(M)) bus ();

    gf2_trinomial_reducer #(.M(M), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always @(posedge bus.done) done_rises++;

    typedef struct {
        string          name;
        logic [2*M-1:0] w;
        logic [M-1:0]   r;
    } vec_t;

    // Polynomial long division: clear each set bit at or above x^M from the top down.
    function automatic logic [M-1:0] ref_reduce(input logic [2*M-1:0] w);
        logic [2*M-1:0] p;
        p = w >> 1;
        for (int i = 2*M-2; i >= M; i--) begin
            if (p[i]) begin
                p[i]       = 1'b0;
                p[i-M+K]   = ~p[i-M+K];
                p[i-M]     = ~p[i-M];
            end
        end
        return p[M-1:0];
    endfunction

    task automatic chk1(input string nm, input logic a, input logic e);
        nchecks++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic chkr(input string nm, input logic [M-1:0] a, input logic [M-1:0] e);
        int fd;
        nchecks++;
        if (a !== e) begin
            nerr++;
            fd = -1;
            for (int i = 0; i < M; i++)
                if (fd < 0 && a[i] !== e[i]) fd = i;
            $display("FAIL %s: got low64=%h expected low64=%h first differing bit %0d",
                     nm, a[63:0], e[63:0], fd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted reduction and checks the fixed three-edge timing.
    task automatic run_op(input string nm, input logic [2*M-1:0] w, input logic [M-1:0] exp_r);
        logic [M-1:0] old_r;
        old_r    = bus.R;
        bus.W     = w;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk1({nm, ".busy_e0"}, bus.busy, 1'b1);
        chk1({nm, ".done_e0"}, bus.done, 1'b0);
`ifdef GF2_RED_ERR_EN
        chk1({nm, ".err"}, bus.err, w[0]);
`endif
        tick();
        chk1({nm, ".busy_e1"}, bus.busy, 1'b1);
        chkr({nm, ".r_held"}, bus.R, old_r);
        tick();
        chk1({nm, ".done_e2"}, bus.done, 1'b1);
        chk1({nm, ".busy_e2"}, bus.busy, 1'b0);
        chkr({nm, ".r"}, bus.R, exp_r);
    endtask

    initial begin
        vec_t           vt[$];
        vec_t           v;
        logic [2*M-1:0] w;
        logic [M-1:0]   e;

        v.name = "unit";     v.w = '0; v.w[1]     = 1'b1; v.r = '0; v.r[0] = 1'b1;                         vt.push_back(v);
        v.name = "xm";       v.w = '0; v.w[M+1]   = 1'b1; v.r = '0; v.r[0] = 1'b1; v.r[9] = 1'b1;          vt.push_back(v);
        v.name = "top";      v.w = '0; v.w[2239]  = 1'b1; v.r = '0; v.r[1118] = 1'b1; v.r[16] = 1'b1; v.r[7] = 1'b1; vt.push_back(v);
        v.name = "xm_1";     v.w = '0; v.w[M]     = 1'b1; v.r = '0; v.r[M-1] = 1'b1;                       vt.push_back(v);
        v.name = "xm_plus1"; v.w = '0; v.w[M+1]   = 1'b1; v.w[1] = 1'b1; v.r = '0; v.r[9] = 1'b1;          vt.push_back(v);
        v.name = "zero";     v.w = '0;                   v.r = '0;                                          vt.push_back(v);

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.W     = '0;
        #3;
        chkr("rst.r", bus.R, '0);
        chk1("rst.busy", bus.busy, 1'b0);
        chk1("rst.done", bus.done, 1'b0);
`ifdef GF2_RED_ERR_EN
        chk1("rst.err", bus.err, 1'b0);
`endif
        tick();
        reset = 1'b1;

        // First edge after reset release must already accept start.
        foreach (vt[i]) run_op(vt[i].name, vt[i].w, vt[i].r);

        // Result and done hold in IDLE.
        repeat (3) tick();
        chk1("hold.done", bus.done, 1'b1);
        chkr("hold.r", bus.R, '0);

        // Back-to-back start while done is high.
        w = '0; w[M+1] = 1'b1; e = '0; e[0] = 1'b1; e[9] = 1'b1;
        run_op("b2b_a", w, e);
        w = '0; w[1] = 1'b1; e = '0; e[0] = 1'b1;
        run_op("b2b_b", w, e);

        // Start while busy is ignored.
        bus.W = '0; bus.W[1] = 1'b1; bus.start = 1'b1;
        tick();
        done_rises = 0;
        bus.W = '0; bus.W[5] = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        repeat (3) tick();
        e = '0; e[0] = 1'b1;
        chkr("busy_ign.r", bus.R, e);
        chk1("busy_ign.done", bus.done, 1'b1);
        chk1("busy_ign.one_rise", done_rises == 1, 1'b1);

        // Reset during FOLD1 takes effect without a clock edge.
        bus.W = '0; bus.W[M+1] = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chkr("midrst.r", bus.R, '0);
        chk1("midrst.busy", bus.busy, 1'b0);
        chk1("midrst.done", bus.done, 1'b0);
        tick();
        reset = 1'b1;
        done_rises = 0;
        repeat (4) tick();
        chk1("midrst.done_stays", bus.done, 1'b0);
        chk1("midrst.no_rise", done_rises == 0, 1'b1);

        // Malformed product with W[0] set: R ignores it, err captures it when enabled.
        w = '0; w[1] = 1'b1; w[0] = 1'b1; e = '0; e[0] = 1'b1;
        run_op("w0_set", w, e);
        w = '0; w[1] = 1'b1;
        run_op("w0_clr", w, e);

        // Randomized products, dense and top-heavy.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 2*M; i += 32) w[i +: 32] = $urandom;
            if (n % 3 == 1) w[M-1:0] = '0;
            if (n % 3 == 2) w = w & ({2*M{1'b1}} << (2*M - 40));
            w[0] = 1'b0;
            run_op($sformatf("rand%0d", n), w, ref_reduce(w));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule

// File: doc/gf2_trinomial_reducer.md
GF2_TRINOMIAL_REDUCER -- requirements
Module: gf2_trinomial_reducer

Interface
REQ-001 SHALL have parameter M, default 1120: the field degree, equal to the multiplier operand width.
REQ-002 SHALL have parameter K, default 9: the middle exponent of the modulus f(x) = x^M + x^K + 1, legal range 1 <= K <= M/2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; reset = 0 resets the block.
REQ-005 SHALL have port start, input, 1 bit: request to reduce W, typically driven by the multiplier's done.
REQ-006 SHALL have port W, input, 2M bits: the product from the upstream multiplier.
- The coefficient of x^k sits at W[k+1].
- W[0] is always zero in a well-formed product.
REQ-007 SHALL have port R, output, M bits: the reduced result; R[k] is the coefficient of x^k of W mod f.
REQ-008 SHALL have port busy, output, 1 bit: high while a reduction is in progress.
REQ-009 SHALL have port done, output, 1 bit: level signal, high while R holds a completed result.

Function
REQ-010 SHALL implement the FSM states IDLE, FOLD1 and FOLD2, with an internal accumulator acc of 2M-1 bits.
REQ-011 SHALL, in IDLE with start=1 at a rising edge:
- load acc <= W[2M-1:1];
- clear done to 0 and set busy to 1;
- go to FOLD1.
REQ-012 SHALL apply one fold per edge in FOLD1 and in FOLD2:
- H = acc[2M-2:M] and L = acc[M-1:0];
- acc <= L ^ H ^ (H << K), zero-extended to 2M-1 bits.
REQ-013 SHALL, at the FOLD2 edge:
- load R <= the low M bits of the folded value;
- set done to 1 and clear busy to 0;
- return to IDLE.
REQ-014 SHALL guarantee the post-FOLD2 bits [2M-2:M] are zero for any K in range; latency is fixed at three edges, with start sampled at edge E and R/done valid after edge E+2.
REQ-015 SHALL ignore start while busy=1; acc, R and the state are unaffected.
REQ-016 SHALL accept start=1 on the same cycle done is high in IDLE (back-to-back operation); done falls and R keeps its old value until the new FOLD2 edge.
REQ-017 SHALL hold R and done stable in IDLE until the next accepted start.
REQ-018 SHALL use XOR-only arithmetic (GF(2)); there is no carry anywhere.

Reset
REQ-019 SHALL, while reset=0, immediately set state=IDLE, acc=0, R=0, busy=0 and done=0, independent of clk.
REQ-020 SHALL, when reset is asserted mid-operation (FOLD1 or FOLD2), abandon the operation; done does not assert for it.
REQ-021 SHALL honour start on the first rising edge after reset deasserts.

Configuration
REQ-022 SHALL, when macro GF2_RED_ERR_EN is defined, add output port err (1 bit, reset value 0).
- err is loaded with W[0] on each accepted start and holds until the next accepted start.
- err is cleared by reset.
REQ-023 SHALL, without GF2_RED_ERR_EN, omit the err port; W[0] is ignored, and R, done and busy behave identically to the macro-enabled build.

Verification
REQ-024 SHALL cover the unit product: M=1120, K=9, W=1<<1, start pulse at edge E -> busy high after E, done=1 and R=1 after E+2.
REQ-025 SHALL cover single-term reduction: W with only bit M+1 set (x^M) -> R has only bits 0 and 9 set (x^9+1).
REQ-026 SHALL cover the top term: W with only bit 2239 set (x^2238) -> R has only bits 1118, 16 and 7 set.
REQ-027 SHALL cover start while busy: start with W=1<<1, then start with W=1<<5 during FOLD1 -> R=1, exactly one done rise.
REQ-028 SHALL cover reset mid-operation: reset=0 during FOLD1 -> R=0, busy=0 and done=0 immediately; done stays 0 until a new start.
REQ-029 SHALL cover the error flag: GF2_RED_ERR_EN defined, W=3 (bit 0 set) -> err=1 and R=1; without the macro, the same stimulus gives R=1.
